// File: rtl/openofdm_tx_bit_framer_if.sv
// Handshake and command bundle between a packet source and the 802.11a/g transmit bit framer.
// master drives commands, PSDU bytes and encoder ready; slave is the framer.
interface openofdm_tx_bit_framer_if;
  logic        start;
  logic [3:0]  pkt_rate;
  logic [11:0] pkt_len;
  logic [6:0]  scr_seed;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic        byte_in_ready;
  logic        bit_out;
  logic        bit_out_valid;
  logic        bit_out_ready;
  logic        bit_is_signal;
  logic        sym_start;
  logic        busy;
  logic        done;
  logic        err;
  logic [14:0] n_ofdm_sym;

  modport master (
    output start, pkt_rate, pkt_len, scr_seed, byte_in, byte_in_valid, bit_out_ready,
    input  byte_in_ready, bit_out, bit_out_valid, bit_is_signal, sym_start, busy, done, err,
           n_ofdm_sym
  );

  modport slave (
    input  start, pkt_rate, pkt_len, scr_seed, byte_in, byte_in_valid, bit_out_ready,
    output byte_in_ready, bit_out, bit_out_valid, bit_is_signal, sym_start, busy, done, err,
           n_ofdm_sym
  );
endinterface

// File: rtl/openofdm_tx_bit_framer.sv
// 802.11a/g transmit bit framer: serialises SIGNAL, SERVICE, DATA, TAIL and PAD with the
// 802.11 scrambler applied to SERVICE/DATA/PAD, flagging OFDM symbol boundaries.
module openofdm_tx_bit_framer #(
  parameter logic [6:0] DEFAULT_SEED = 7'h5D
) (
  input logic                     clock,
  input logic                     reset,
  openofdm_tx_bit_framer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_SIGNAL, S_SERVICE, S_DATA, S_TAIL, S_PAD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] sig_q, sig_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  sym_cnt_q, sym_cnt_d;
  logic [7:0]  ndbps_q, ndbps_d;
  logic [14:0] nsym_q, nsym_d;
  logic [6:0]  scr_q, scr_d;
  logic [11:0] len_q, len_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] sent_q, sent_d;
  logic [7:0]  byte_q, byte_d;
  logic        full_q, full_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        err_q, err_d;

  logic        fb, xfer, sym_wrap, out_bit, out_valid, byte_take, scr_adv, sym_adv;
  logic [7:0]  ndbps_dec;
  logic [23:0] sig_new;

  // pkt_rate[3] is R1, so 4'b1101 reads as the 6 Mb/s code
  always_comb begin
    case (bus.pkt_rate)
      4'b1101: ndbps_dec = 8'd24;
      4'b1111: ndbps_dec = 8'd36;
      4'b0101: ndbps_dec = 8'd48;
      4'b0111: ndbps_dec = 8'd72;
      4'b1001: ndbps_dec = 8'd96;
      4'b1011: ndbps_dec = 8'd144;
      4'b0001: ndbps_dec = 8'd192;
      4'b0011: ndbps_dec = 8'd216;
      default: ndbps_dec = 8'd0;
    endcase
  end

  // SIGNAL word in transmit order, bit 0 goes out first
  always_comb begin
    sig_new       = '0;
    sig_new[3:0]  = {bus.pkt_rate[0], bus.pkt_rate[1], bus.pkt_rate[2], bus.pkt_rate[3]};
    sig_new[16:5] = bus.pkt_len;
    sig_new[17]   = ^sig_new[16:0];
  end

  assign fb       = scr_q[6] ^ scr_q[3];
  assign sym_wrap = (sym_cnt_q == ndbps_q - 8'd1);

  always_comb begin
    out_bit   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_SIGNAL:  begin out_bit = sig_q[0];                 out_valid = 1'b1;   end
      S_SERVICE: begin out_bit = fb;                       out_valid = 1'b1;   end
      S_DATA:    begin out_bit = byte_q[bit_idx_q] ^ fb;   out_valid = full_q; end
      S_TAIL:    begin out_bit = 1'b0;                     out_valid = 1'b1;   end
      S_PAD:     begin out_bit = fb;                       out_valid = 1'b1;   end
      default:   ;
    endcase
  end

  assign xfer    = out_valid & bus.bit_out_ready;
  assign scr_adv = xfer & (state_q inside {S_SERVICE, S_DATA, S_PAD});
  assign sym_adv = xfer & (state_q inside {S_SERVICE, S_DATA, S_TAIL, S_PAD});

  // Refill may overlap the transfer of the current byte's last bit
  assign bus.byte_in_ready = (state_q == S_DATA) && (acc_q != len_q) &&
                             (!full_q || (xfer && bit_idx_q == 3'd7));
  assign byte_take         = bus.byte_in_ready & bus.byte_in_valid;

  assign bus.bit_out       = out_bit;
  assign bus.bit_out_valid = out_valid;
  assign bus.bit_is_signal = (state_q == S_SIGNAL);
  assign bus.sym_start     = ((state_q == S_SIGNAL) && (cnt_q == 5'd0)) ||
                             ((state_q inside {S_SERVICE, S_DATA, S_TAIL, S_PAD}) &&
                              (sym_cnt_q == 8'd0));
  assign bus.busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.err           = err_q;
  assign bus.n_ofdm_sym    = nsym_q;

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    sym_cnt_d = sym_cnt_q;
    ndbps_d   = ndbps_q;
    nsym_d    = nsym_q;
    scr_d     = scr_q;
    len_d     = len_q;
    acc_d     = acc_q;
    sent_d    = sent_q;
    byte_d    = byte_q;
    full_d    = full_q;
    bit_idx_d = bit_idx_q;
    err_d     = 1'b0;

    if (scr_adv) scr_d = {scr_q[5:0], fb};
    if (sym_adv) begin
      sym_cnt_d = sym_wrap ? 8'd0 : sym_cnt_q + 8'd1;
      nsym_d    = nsym_q + {14'd0, sym_wrap};
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (ndbps_dec != 8'd0 && bus.pkt_len != 12'd0) begin
            state_d   = S_SIGNAL;
            sig_d     = sig_new;
            len_d     = bus.pkt_len;
            ndbps_d   = ndbps_dec;
            scr_d     = (bus.scr_seed == 7'd0) ? DEFAULT_SEED : bus.scr_seed;
            nsym_d    = '0;
            cnt_d     = '0;
            sym_cnt_d = '0;
            acc_d     = '0;
            sent_d    = '0;
            full_d    = 1'b0;
            bit_idx_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SIGNAL: begin
        if (xfer) begin
          sig_d = sig_q >> 1;
          if (cnt_q == 5'd23) begin
            cnt_d   = '0;
            state_d = S_SERVICE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_SERVICE: begin
        if (xfer) begin
          if (cnt_q == 5'd15) begin
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            full_d = 1'b0;
            sent_d = sent_q + 12'd1;
            if (sent_q == len_q - 12'd1) state_d = S_TAIL;
          end
        end
        if (byte_take) begin
          byte_d = bus.byte_in;
          full_d = 1'b1;
          acc_d  = acc_q + 12'd1;
        end
      end
      S_TAIL: begin
        if (xfer) begin
          if (cnt_q == 5'd5) begin
            cnt_d   = '0;
            // A tail ending exactly on a symbol boundary needs no pad
            state_d = sym_wrap ? S_DONE : S_PAD;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_PAD: begin
        if (xfer && sym_wrap) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sig_q     <= '0;
      cnt_q     <= '0;
      sym_cnt_q <= '0;
      ndbps_q   <= '0;
      nsym_q    <= '0;
      scr_q     <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      sent_q    <= '0;
      byte_q    <= '0;
      full_q    <= 1'b0;
      bit_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      sym_cnt_q <= sym_cnt_d;
      ndbps_q   <= ndbps_d;
      nsym_q    <= nsym_d;
      scr_q     <= scr_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      sent_q    <= sent_d;
      byte_q    <= byte_d;
      full_q    <= full_d;
      bit_idx_q <= bit_idx_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_openofdm_tx_bit_framer.sv
// Directed bench for openofdm_tx_bit_framer: framing, scrambling, padding, backpressure,
// error/ignore handling, reset and seed substitution.
module tb_openofdm_tx_bit_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  openofdm_tx_bit_framer_if bus();

  openofdm_tx_bit_framer #(.DEFAULT_SEED(7'h5D)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  bit got_bits[$], got_sig[$], got_sym[$], exp_bits[$], ref_bits[$];
  int done_cyc, last_xfer, stab_viol, bytes_taken, exp_nsym;
  bit done_seen, aborted, first_ok, busy_at_done, pat_zero;
  logic [14:0] nsym_at_done;

  function automatic logic [7:0] pat(input int i);
    logic [7:0] v;
    v = 8'(i * 37 + 5);
    return pat_zero ? 8'h00 : v;
  endfunction

  function automatic int stream_diff(input bit a[$], input bit b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  // Reference stream built straight from the frame definition
  function automatic void build_exp(input logic [3:0] rate, input logic [11:0] len,
                                    input logic [6:0] seed);
    int nd, total, nsym, pad;
    logic [6:0] s;
    logic [7:0] d;
    logic b, f;
    exp_bits.delete();
    case (rate)
      4'b1101: nd = 24;  4'b1111: nd = 36;  4'b0101: nd = 48;  4'b0111: nd = 72;
      4'b1001: nd = 96;  4'b1011: nd = 144; 4'b0001: nd = 192; 4'b0011: nd = 216;
      default: nd = 1;
    endcase
    for (int i = 3; i >= 0; i--) exp_bits.push_back(rate[i]);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 12; i++) exp_bits.push_back(len[i]);
    exp_bits.push_back(^{rate, len});
    repeat (6) exp_bits.push_back(1'b0);
    s = (seed == 7'd0) ? 7'h5D : seed;
    for (int i = 0; i < 16 + 8 * int'(len); i++) begin
      b = 1'b0;
      if (i >= 16) begin
        d = pat((i - 16) / 8);
        b = d[(i - 16) % 8];
      end
      f = s[6] ^ s[3];
      exp_bits.push_back(b ^ f);
      s = {s[5:0], f};
    end
    repeat (6) exp_bits.push_back(1'b0);
    total = 22 + 8 * int'(len);
    nsym = (total + nd - 1) / nd;
    pad = nsym * nd - total;
    exp_nsym = nsym;
    for (int i = 0; i < pad; i++) begin
      f = s[6] ^ s[3];
      exp_bits.push_back(f);
      s = {s[5:0], f};
    end
  endfunction

  task automatic run_packet(input logic [3:0] rate, input logic [11:0] len, input logic [6:0] seed,
                            input bit bp, input bit mid_start, input int abort_at);
    int cyc, nb;
    bit prev_hold;
    logic [2:0] prev_flags;
    got_bits.delete(); got_sig.delete(); got_sym.delete();
    nb = 0; stab_viol = 0; done_seen = 0; aborted = 0; first_ok = 0;
    prev_hold = 0; prev_flags = '0; last_xfer = -1; done_cyc = -1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pkt_rate = rate; bus.pkt_len = len; bus.scr_seed = seed;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (cyc = 0; cyc < 20000 && !done_seen && !aborted; cyc++) begin
      bus.bit_out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.byte_in_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.byte_in = pat(nb);
      bus.start = mid_start && (cyc == 50);
      if (mid_start && cyc == 50) begin
        bus.pkt_rate = 4'b0011;
        bus.pkt_len = 12'd1;
      end
      @(negedge clk);
      if (cyc == 0)
        first_ok = bus.busy && bus.bit_out_valid && (bus.bit_out === rate[3]) &&
                   bus.bit_is_signal && bus.sym_start;
      if (prev_hold && (!bus.bit_out_valid ||
          {bus.bit_out, bus.bit_is_signal, bus.sym_start} !== prev_flags))
        stab_viol++;
      if (bus.done) begin
        done_seen = 1; done_cyc = cyc; busy_at_done = bus.busy; nsym_at_done = bus.n_ofdm_sym;
      end else if (bus.bit_out_valid && bus.bit_out_ready) begin
        got_bits.push_back(bus.bit_out);
        got_sig.push_back(bus.bit_is_signal);
        got_sym.push_back(bus.sym_start);
        last_xfer = cyc;
        if (abort_at != 0 && got_bits.size() == abort_at) aborted = 1;
      end
      prev_hold = bus.bit_out_valid && !bus.bit_out_ready;
      prev_flags = {bus.bit_out, bus.bit_is_signal, bus.sym_start};
      if (bus.byte_in_ready && bus.byte_in_valid) nb++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.bit_out_ready = 1'b1;
    bytes_taken = nb;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.byte_in_ready, bus.bit_out, bus.bit_out_valid, bus.bit_is_signal, bus.sym_start,
         bus.busy, bus.done, bus.err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000", {bus.byte_in_ready, bus.bit_out,
               bus.bit_out_valid, bus.bit_is_signal, bus.sym_start, bus.busy, bus.done, bus.err});
    end
    checks++;
    if (bus.n_ofdm_sym !== 15'd0) begin
      errors++; $display("FAIL reset_nsym got %0d want 0", bus.n_ofdm_sym);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.bit_out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b valid=%b want 0 0", bus.busy, bus.bit_out_valid);
    end
  endtask

  task automatic test_signal_field();
    logic [23:0] sig_exp;
    int bad_sig, bad_sym;
    sig_exp = 24'b110100010011000000000000;
    build_exp(4'b1101, 12'd100, 7'h2A);
    run_packet(4'b1101, 12'd100, 7'h2A, 0, 0, 0);
    checks++;
    if (!done_seen) begin errors++; $display("FAIL sig_timeout got no done want done"); end
    checks++;
    if (!first_ok) begin errors++; $display("FAIL sig_first_bit got not R1/busy at T+1 want R1 valid busy"); end
    bad_sig = 0;
    for (int i = 0; i < 24 && i < got_bits.size(); i++)
      if (got_bits[i] !== sig_exp[23 - i] || got_sig[i] !== 1'b1) bad_sig++;
    checks++;
    if (bad_sig !== 0 || got_bits.size() < 24) begin
      errors++; $display("FAIL sig_bits got %0d bad bits want 0", bad_sig);
    end
    checks++;
    if (got_bits.size() - 24 !== 840) begin
      errors++; $display("FAIL sig_post_count got %0d want 840", got_bits.size() - 24);
    end
    checks++;
    if (nsym_at_done !== 15'd35) begin
      errors++; $display("FAIL sig_nsym got %0d want 35", nsym_at_done);
    end
    bad_sym = 0;
    for (int i = 0; i < got_sym.size(); i++)
      if (got_sym[i] !== ((i == 0) || (i >= 24 && (i - 24) % 24 == 0)) ||
          (i >= 24 && got_sig[i] !== 1'b0)) bad_sym++;
    checks++;
    if (bad_sym !== 0) begin errors++; $display("FAIL sig_sym_start got %0d bad flags want 0", bad_sym); end
    checks++;
    if (stream_diff(got_bits, exp_bits) != -1) begin
      errors++; $display("FAIL sig_stream got diff at %0d want none", stream_diff(got_bits, exp_bits));
    end
    checks++;
    if (done_cyc - last_xfer !== 1 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL sig_done_timing got gap=%0d busy=%b want 1 0", done_cyc - last_xfer, busy_at_done);
    end
  endtask

  task automatic test_scrambler();
    logic [23:0] scr_exp;
    int bad;
    scr_exp = 24'b0000111011110010_11001001;
    pat_zero = 1;
    build_exp(4'b1101, 12'd1, 7'h7F);
    run_packet(4'b1101, 12'd1, 7'h7F, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 24 && 24 + i < got_bits.size(); i++)
      if (got_bits[24 + i] !== scr_exp[23 - i]) bad++;
    checks++;
    if (bad !== 0 || got_bits.size() != 72) begin
      errors++; $display("FAIL scr_service_data got %0d bad of %0d bits want 0 of 72", bad, got_bits.size());
    end
    bad = 0;
    for (int i = 48; i < 54 && i < got_bits.size(); i++) if (got_bits[i] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL scr_tail got %0d ones want 0", bad); end
    checks++;
    if (stream_diff(got_bits, exp_bits) != -1) begin
      errors++; $display("FAIL scr_pad got diff at %0d want none", stream_diff(got_bits, exp_bits));
    end
    pat_zero = 0;
  endtask

  task automatic test_single_symbol();
    build_exp(4'b0011, 12'd1, 7'h01);
    run_packet(4'b0011, 12'd1, 7'h01, 0, 0, 0);
    checks++;
    if (got_bits.size() !== 24 + 216 || nsym_at_done !== 15'd1) begin
      errors++; $display("FAIL single_size got %0d bits nsym=%0d want 240 nsym=1", got_bits.size(), nsym_at_done);
    end
    checks++;
    if (stream_diff(got_bits, exp_bits) != -1) begin
      errors++; $display("FAIL single_stream got diff at %0d want none", stream_diff(got_bits, exp_bits));
    end
    checks++;
    if (done_cyc - last_xfer !== 1) begin
      errors++; $display("FAIL single_done_gap got %0d want 1", done_cyc - last_xfer);
    end
  endtask

  task automatic test_backpressure();
    build_exp(4'b0101, 12'd20, 7'h03);
    run_packet(4'b0101, 12'd20, 7'h03, 0, 0, 0);
    ref_bits = got_bits;
    checks++;
    if (stream_diff(ref_bits, exp_bits) != -1) begin
      errors++; $display("FAIL bp_free_stream got diff at %0d want none", stream_diff(ref_bits, exp_bits));
    end
    run_packet(4'b0101, 12'd20, 7'h03, 1, 0, 0);
    checks++;
    if (!done_seen || stream_diff(got_bits, ref_bits) != -1) begin
      errors++; $display("FAIL bp_stream got diff at %0d done=%b want none", stream_diff(got_bits, ref_bits), done_seen);
    end
    checks++;
    if (stab_viol !== 0) begin errors++; $display("FAIL bp_hold got %0d changes want 0", stab_viol); end
    checks++;
    if (bytes_taken !== 20) begin errors++; $display("FAIL bp_bytes got %0d want 20", bytes_taken); end
  endtask

  task automatic test_errors();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pkt_rate = 4'b0000; bus.pkt_len = 12'd5; bus.scr_seed = 7'h11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL err_rate got err=%b busy=%b want 1 0", bus.err, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.bit_out_valid !== 1'b0) begin
      errors++; $display("FAIL err_pulse got err=%b valid=%b want 0 0", bus.err, bus.bit_out_valid);
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pkt_rate = 4'b1101; bus.pkt_len = 12'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL err_len0 got err=%b busy=%b want 1 0", bus.err, bus.busy);
    end
    build_exp(4'b1001, 12'd30, 7'h44);
    run_packet(4'b1001, 12'd30, 7'h44, 0, 1, 0);
    checks++;
    if (!done_seen || stream_diff(got_bits, exp_bits) != -1) begin
      errors++; $display("FAIL busy_start_ignored got diff at %0d want none", stream_diff(got_bits, exp_bits));
    end
  endtask

  task automatic test_reset_mid();
    run_packet(4'b1101, 12'd100, 7'h2A, 0, 0, 300);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.byte_in_ready, bus.bit_out, bus.bit_out_valid, bus.bit_is_signal, bus.sym_start,
         bus.busy, bus.done, bus.err, bus.n_ofdm_sym} !== 23'b0) begin
      errors++;
      $display("FAIL mid_reset got valid=%b busy=%b done=%b nsym=%0d want all 0",
               bus.bit_out_valid, bus.busy, bus.done, bus.n_ofdm_sym);
    end
    rst = 1'b0;
    build_exp(4'b1111, 12'd7, 7'h09);
    run_packet(4'b1111, 12'd7, 7'h09, 0, 0, 0);
    checks++;
    if (!done_seen || stream_diff(got_bits, exp_bits) != -1 || nsym_at_done !== 15'(exp_nsym)) begin
      errors++; $display("FAIL after_reset got diff at %0d nsym=%0d want none nsym=%0d",
                         stream_diff(got_bits, exp_bits), nsym_at_done, exp_nsym);
    end
  endtask

  task automatic test_seed_zero();
    build_exp(4'b0111, 12'd10, 7'h5D);
    run_packet(4'b0111, 12'd10, 7'h00, 0, 0, 0);
    checks++;
    if (!done_seen || stream_diff(got_bits, exp_bits) != -1) begin
      errors++; $display("FAIL seed_zero got diff at %0d want none", stream_diff(got_bits, exp_bits));
    end
    ref_bits = got_bits;
    run_packet(4'b0111, 12'd10, 7'h5D, 0, 0, 0);
    checks++;
    if (stream_diff(got_bits, ref_bits) != -1) begin
      errors++; $display("FAIL seed_5d_vs_0 got diff at %0d want none", stream_diff(got_bits, ref_bits));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.pkt_rate = '0; bus.pkt_len = '0; bus.scr_seed = '0;
    bus.byte_in = '0; bus.byte_in_valid = 1'b0; bus.bit_out_ready = 1'b0;
    pat_zero = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_signal_field();
    test_scrambler();
    test_single_symbol();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_seed_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
